fetch_redirect_unit: RTL
========================

# fetch_redirect_unit

- Front-end PC generator and fetch queue.
- Consumes the branch-unit redirect (valid, target PC, scoreboard id) and issues sequential 4-byte instruction fetches to instruction memory over a valid/ready request port.
- Buffers in-order fetch responses in a small queue feeding decode.
- On redirect: discards every stale in-flight response and queued instruction, restarts fetch at the target, and broadcasts a one-cycle flush tagged with the redirecting sid.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- FQ_DEPTH, 4, fetch-queue entries; power of two, 2..16
- SID_W, `SCOREBOARD_SIZE_WIDTH`, scoreboard id width

Ports (clk, reset first):
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- redirect_valid_i  in  1  branch redirect request
- redirect_pc_i  in  64  redirect target PC
- redirect_sid_i  in  SID_W  sid of the redirecting branch
- flush_o  out  1  one-cycle pipeline flush pulse
- flush_sid_o  out  SID_W  sid associated with flush_o
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  imem accepts request
- imem_req_addr_o  out  64  fetch address, 4-byte aligned
- imem_resp_valid_i  in  1  in-order response valid; no backpressure
- imem_resp_data_i  in  32  fetched instruction
- inst_valid_o  out  1  queue head valid to decode
- inst_ready_i  in  1  decode accepts head
- inst_pc_o  out  64  PC of head instruction
- inst_o  out  32  head instruction
- misalign_o  out  1  misaligned-redirect halt flag (feature-dependent)

## Operation
- State: pc_r (next fetch address), outstanding counter, drop counter, and a circular queue with separate read and write pointers. Each entry holds {pc, inst}.
- Counters: outstanding and drop are each clog2(FQ_DEPTH+1) bits wide.
- FSM:
  - BOOT → RUN on the first cycle after reset. No request is issued in BOOT.
  - RUN → HALT only on a misaligned redirect when MISALIGN_TRAP is enabled.
  - HALT → RUN only on an aligned redirect.
- Request issue: imem_req_valid_o = RUN & (outstanding + fq_count < FQ_DEPTH). On each handshake, pc_r += 4 and outstanding increments.
- Address stability: imem_req_addr_o = pc_r. It is stable while valid & !ready, except when a redirect occurs.
- Response handling:
  - Every response decrements outstanding.
  - If drop > 0, the response is discarded and drop decrements.
  - Otherwise it is enqueued with its PC. A separate resp_pc_r tracks the PC of the next expected response.
- Redirect sampled in cycle N:
  - Queue is cleared.
  - pc_r and resp_pc_r are set to redirect_pc_i.
  - drop is set to outstanding after cycle-N updates: requests handshaked in N count as stale, responses received in N are discarded.
  - flush_o=1 and flush_sid_o=redirect_sid_i during N+1.
- Decode port: inst_valid_o = fq_nonempty & ~redirect_valid_i. No instruction is handed to decode in a redirect cycle.
- Arithmetic: PC adds wrap modulo 2^64. Counters never exceed FQ_DEPTH, guaranteed by the credit check.

## Timing
- Reset values: flush_o=0, flush_sid_o=0, imem_req_valid_o=0, imem_req_addr_o=RESET_PC, inst_valid_o=0, inst_pc_o=0, inst_o=0, misalign_o=0. Counters and pointers are 0; FSM is in BOOT.
- First request is valid in cycle 1 after reset deassertion.
- Response-to-decode latency is 1 cycle: a response enqueued at edge N is visible as inst_valid_o in N+1.
- Redirect in cycle N: the request in N+1 carries the new target.
- Full queue: request valid stays low until decode dequeues. Dequeue and enqueue may occur in the same cycle.
- Empty queue: inst_valid_o=0.
- Simultaneous redirect and response: the response is stale and dropped.
- Simultaneous redirect and request handshake: the request counts toward drop.
- Reset mid-operation: all state returns to reset values immediately.

## Configuration
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]≠0 flushes the front end as normal, enters HALT, and sets misalign_o=1 from the next cycle.
  - No requests are issued while in HALT. Stale responses still drain.
  - An aligned redirect clears misalign_o and returns to RUN.
- Undefined: redirect_pc_i[1:0] is forced to 0, misalign_o is tied 0, and the HALT state is absent.

## Structure
- Shared package: RESET_PC default, FQ entry struct {pc[63:0], inst[31:0]}, and FSM state encoding (BOOT, RUN, HALT).
- One sub-module: fetch_queue, a parameterized synchronous circular FIFO with a clear input.

## Test plan
- Reset, ready tied 1: requests issue at 0x80000000, 0x80000004, 0x80000008 on consecutive cycles → responses appear at decode with matching PCs, 1 cycle after each response.
- inst_ready_i=0, FQ_DEPTH=4, imem responds in 1 cycle: exactly 4 requests issue, then imem_req_valid_o=0 until one dequeue, after which 1 further request issues.
- 2 requests outstanding, redirect to 0x80001000 with sid=3 → flush_o=1 and flush_sid_o=3 next cycle; next 2 responses are dropped; next request addr is 0x80001000; first enqueued inst_pc_o is 0x80001000.
- Redirect in the same cycle as a response and a request handshake → both are treated as stale; queue is empty after the redirect.
- Redirect to 0x80001002, macro defined → misalign_o=1 and no requests issue. A subsequent redirect to 0x80002000 resumes fetch at 0x80002000.
- Same misaligned redirect with the macro undefined → fetch resumes at 0x80001000.
- Assert rst_n low while 3 requests are outstanding → all outputs return to reset values; after reset, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the fetch redirect unit.
// SCOREBOARD_SIZE_WIDTH falls back to 4 when the surrounding build does not provide it.
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package fetch_redirect_unit_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_fetch_queue.sv
// Circular FIFO of {pc, inst} entries feeding decode; clear empties it in one cycle.
module fetch_queue
  import fetch_redirect_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  output fq_entry_t                head_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;
  assign not_empty = (count != '0);

endmodule

// File: rtl/fetch_redirect_unit.sv
// Front-end PC generator and fetch queue with branch-redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to halt fetch on a misaligned redirect target.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 4,
  parameter int          SID_W    = `SCOREBOARD_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid_i,
  input  logic [63:0]      redirect_pc_i,
  input  logic [SID_W-1:0] redirect_sid_i,
  output logic             flush_o,
  output logic [SID_W-1:0] flush_sid_o,
  output logic             imem_req_valid_o,
  input  logic             imem_req_ready_i,
  output logic [63:0]      imem_req_addr_o,
  input  logic             imem_resp_valid_i,
  input  logic [31:0]      imem_resp_data_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [63:0]      inst_pc_o,
  output logic [31:0]      inst_o,
  output logic             misalign_o
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [1:0]       state_r;
  logic [1:0]       state_next;
  logic [63:0]      pc_r;
  logic [63:0]      resp_pc_r;
  logic [63:0]      target_pc;
  logic [CW-1:0]    outstanding_r;
  logic [CW-1:0]    outstanding_next;
  logic [CW-1:0]    drop_r;
  logic [CW-1:0]    fq_count;
  logic             misaligned;
  logic             req_fire;
  logic             fq_push;
  logic             fq_pop;
  logic             fq_not_empty;
  logic             flush_r;
  logic [SID_W-1:0] flush_sid_r;
  fq_entry_t        fq_in;
  fq_entry_t        fq_head;

  assign target_pc = align_pc(redirect_pc_i);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign misalign_o = (state_r == ST_HALT);
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Credit check: in-flight requests plus queued entries never exceed the queue size.
  assign imem_req_valid_o = (state_r == ST_RUN) &&
                            (({1'b0, outstanding_r} + {1'b0, fq_count}) < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr_o  = pc_r;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  assign outstanding_next = outstanding_r + CW'(req_fire) - CW'(imem_resp_valid_i);

  assign fq_push      = imem_resp_valid_i && (drop_r == '0) && !redirect_valid_i;
  assign inst_valid_o = fq_not_empty & ~redirect_valid_i;
  assign fq_pop       = inst_valid_o & inst_ready_i;
  assign fq_in        = '{pc: resp_pc_r, inst: imem_resp_data_i};
  assign inst_pc_o    = fq_head.pc;
  assign inst_o       = fq_head.inst;

  assign flush_o     = flush_r;
  assign flush_sid_o = flush_sid_r;

  always_comb begin
    state_next = state_r;
    if (redirect_valid_i) begin
      state_next = misaligned ? ST_HALT : ST_RUN;
    end else if (state_r == ST_BOOT) begin
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_next;
    end
  end

  // Everything in flight at a redirect, including this cycle's handshake, is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= '0;
      drop_r        <= '0;
    end else begin
      outstanding_r <= outstanding_next;
      if (redirect_valid_i) begin
        pc_r      <= target_pc;
        resp_pc_r <= target_pc;
        drop_r    <= outstanding_next;
      end else begin
        if (req_fire) pc_r <= pc_r + 64'd4;
        if (fq_push)  resp_pc_r <= resp_pc_r + 64'd4;
        if (imem_resp_valid_i && (drop_r != '0)) drop_r <= drop_r - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_r     <= 1'b0;
      flush_sid_r <= '0;
    end else begin
      flush_r <= redirect_valid_i;
      if (redirect_valid_i) flush_sid_r <= redirect_sid_i;
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid_i),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .head_data (fq_head),
    .not_empty (fq_not_empty),
    .count     (fq_count)
  );

endmodule
